// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: prefix stall mask, exception flush sequencing with redirect PC, and stall-duration watchdog
module pipe_stall_ctrl #(
    parameter int NUM_STAGES    = 6,
    parameter int ADDR_W        = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int CNT_W         = 8,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  flush_req,
    input  logic [ADDR_W-1:0]     exc_newpc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [ADDR_W-1:0]     new_pc,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  stall_timeout
);
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    typedef enum logic {RUN, FLUSH} state_t;
    state_t            state;
    logic [FW-1:0]     fcnt;
    logic [ADDR_W-1:0] pc_q;
    logic [NUM_STAGES-1:0] mask;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              to_q, in_flush, acc;
    if (FLUSH_CYCLES < 1) begin : g_bad_param
        $error("pipe_stall_ctrl: FLUSH_CYCLES must be >= 1");
    end
    // a stalled stage must also hold every stage behind it
    always_comb begin
        mask = '0;
        acc  = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc     = acc | stall_req[i];
            mask[i] = acc;
        end
    end
    assign in_flush      = state == FLUSH;
    assign flush         = !rst && (in_flush || flush_req);
    assign new_pc        = rst ? '0 : in_flush ? pc_q : flush_req ? exc_newpc : '0;
    assign stall         = (rst || flush) ? '0 : mask;
    assign cnt_n         = stall == '0 ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign stall_cnt     = rst ? '0 : cnt_q;
    assign stall_timeout = !rst && to_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
            pc_q  <= '0;
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            if (STALL_TIMEOUT != 0 && 32'(cnt_n) == STALL_TIMEOUT) to_q <= 1'b1;
            if (in_flush) begin
                fcnt <= fcnt - 1'b1;
                if (fcnt == FW'(1)) state <= RUN;
            end else if (flush_req) begin
                pc_q <= exc_newpc;
                fcnt <= FW'(FLUSH_CYCLES - 1);
                if (FLUSH_CYCLES > 1) state <= FLUSH;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: two differently parameterised instances checked against a remaining-cycles reference model
module tb_pipe_stall_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall_req = '0;
    logic        flush_req = 1'b0;
    logic [31:0] exc_newpc = '0;
    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b, to_a, to_b;
    logic [31:0] pc_a, pc_b;
    logic [7:0]  cnt_a;
    logic [2:0]  cnt_b;
    int checks = 0;
    int errors = 0;
    int fc[2]  = '{3, 1};
    int cw[2]  = '{8, 3};
    int tmo[2] = '{4, 0};
    int rem[2], mcnt[2];
    logic [31:0] mpc[2];
    bit mto[2];

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.NUM_STAGES(6), .ADDR_W(32), .FLUSH_CYCLES(3), .CNT_W(8), .STALL_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .exc_newpc(exc_newpc),
        .stall(stall_a), .flush(flush_a), .new_pc(pc_a), .stall_cnt(cnt_a), .stall_timeout(to_a));
    pipe_stall_ctrl #(.NUM_STAGES(6), .ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(3), .STALL_TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .exc_newpc(exc_newpc),
        .stall(stall_b), .flush(flush_b), .new_pc(pc_b), .stall_cnt(cnt_b), .stall_timeout(to_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int prefix_mask(input logic [5:0] r);
        int h = -1;
        for (int i = 0; i < 6; i++) if (r[i]) h = i;
        return h < 0 ? 0 : (1 << (h + 1)) - 1;
    endfunction

    task automatic step(input bit r, input logic [5:0] sr, input bit fr, input logic [31:0] pc);
        int e_stall[2];
        bit e_flush[2];
        logic [31:0] e_pc[2];
        @(negedge clk);
        rst = r; stall_req = sr; flush_req = fr; exc_newpc = pc;
        #1;
        for (int k = 0; k < 2; k++) begin
            e_flush[k] = !r && (rem[k] > 0 || fr);
            e_pc[k]    = r ? 32'h0 : rem[k] > 0 ? mpc[k] : fr ? pc : 32'h0;
            e_stall[k] = (r || e_flush[k]) ? 0 : prefix_mask(sr);
        end
        chk("a.stall", 32'(stall_a), 32'(e_stall[0]));
        chk("a.flush", 32'(flush_a), 32'(e_flush[0]));
        chk("a.new_pc", pc_a, e_pc[0]);
        chk("a.stall_cnt", 32'(cnt_a), r ? 0 : 32'(mcnt[0]));
        chk("a.stall_timeout", 32'(to_a), r ? 0 : 32'(mto[0]));
        chk("b.stall", 32'(stall_b), 32'(e_stall[1]));
        chk("b.flush", 32'(flush_b), 32'(e_flush[1]));
        chk("b.new_pc", pc_b, e_pc[1]);
        chk("b.stall_cnt", 32'(cnt_b), r ? 0 : 32'(mcnt[1]));
        chk("b.stall_timeout", 32'(to_b), r ? 0 : 32'(mto[1]));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                rem[k] = 0; mpc[k] = 0; mcnt[k] = 0; mto[k] = 0;
            end else begin
                if (rem[k] > 0) rem[k]--;
                else if (fr) begin rem[k] = fc[k] - 1; mpc[k] = pc; end
                mcnt[k] = e_stall[k] != 0 ? ((mcnt[k] + 1 > (1 << cw[k]) - 1) ? (1 << cw[k]) - 1 : mcnt[k] + 1) : 0;
                if (tmo[k] != 0 && mcnt[k] == tmo[k]) mto[k] = 1;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin rem[k] = 0; mpc[k] = 0; mcnt[k] = 0; mto[k] = 0; end
        step(1, 6'b111111, 1, 32'hDEAD_BEEF);
        step(1, 6'b000000, 0, 32'h0);
        step(0, 6'b001000, 0, 32'h0);
        chk("a.mask_req3", 32'(stall_a), 32'h0F);
        step(0, 6'b000100, 0, 32'h0);
        step(0, 6'b001010, 0, 32'h0);
        step(0, 6'b001000, 1, 32'h0000_0020);
        step(0, 6'b000000, 0, 32'h0);
        repeat (3) step(0, 6'b000000, 0, 32'h0);
        step(0, 6'b000000, 1, 32'hBFC0_0380);
        step(0, 6'b010000, 1, 32'h1234_5678);
        step(0, 6'b000000, 0, 32'h0);
        step(0, 6'b000000, 0, 32'h0);
        chk("a.flush_done", 32'(flush_a), 32'h0);
        repeat (6) step(0, 6'b000100, 0, 32'h0);
        repeat (3) step(0, 6'b000000, 0, 32'h0);
        chk("a.timeout_sticky", 32'(to_a), 32'h1);
        repeat (10) step(0, 6'b000010, 0, 32'h0);
        chk("b.cnt_saturated", 32'(cnt_b), 32'h7);
        step(0, 6'b000000, 1, 32'h8000_0180);
        step(1, 6'b000001, 0, 32'h0);
        step(0, 6'b000000, 0, 32'h0);
        step(0, 6'b000001, 0, 32'h0);
        repeat (400) begin
            logic [5:0] sr;
            sr = 6'($urandom);
            if ($urandom_range(0, 3) == 0) sr = '0;
            step($urandom_range(0, 49) == 0, sr, $urandom_range(0, 9) == 0, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
